window_scan_ctrl: RTL and testbench

//  Sequencer for the 3x3 windowBuffer in the Sobel edge-detection path.

---
 rtl/sobel_pkg.sv | 43 ++++
 rtl/window_addr_gen.sv | 136 +++++++++++++
 rtl/window_scan_ctrl.sv | 151 +++++++++++++++
 tb/tb_window_scan_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and constants for the Sobel window scan path.
package sobel_pkg;

  // Shift command encoding understood by windowBuffer.
  typedef enum logic [1:0] {
    DIR_NONE  = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } shift_dir_t;

  // Top-level scan sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_PRESENT,
    ST_SHIFT,
    ST_EDGE,
    ST_DONE
  } scan_state_t;

  // Kind of read burst the address generator is currently walking.
  //   RD_FILL : full 3x3 load, slots 0..8
  //   RD_COL  : one new column (after a left/right shift), slot step 3
  //   RD_ROW  : one new row (after a down shift), slot step 1
  typedef enum logic [1:0] {
    RD_FILL,
    RD_COL,
    RD_ROW
  } rd_mode_t;

  // Window slots, row-major, 0 = top-left.
  localparam logic [3:0] SLOT_TL = 4'd0;
  localparam logic [3:0] SLOT_TC = 4'd1;
  localparam logic [3:0] SLOT_TR = 4'd2;
  localparam logic [3:0] SLOT_ML = 4'd3;
  localparam logic [3:0] SLOT_MC = 4'd4;
  localparam logic [3:0] SLOT_MR = 4'd5;
  localparam logic [3:0] SLOT_BL = 4'd6;
  localparam logic [3:0] SLOT_BC = 4'd7;
  localparam logic [3:0] SLOT_BR = 4'd8;

endpackage

// File: rtl/window_addr_gen.sv
// Tracks the window centre and walks the pixel addresses / window slots
// needed to fill or refresh the 3x3 window. Row bases are kept as running
// sums so no multiplier is needed for row*IMG_W.
module window_addr_gen
  import sobel_pkg::*;
#(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              advance,
  input  logic              move,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [3:0]        buf_idx,
  output logic [ADDR_W-1:0] centre_row,
  output logic [ADDR_W-1:0] centre_col,
  output logic              last_read,
  output logic              last_window,
  output shift_dir_t        next_dir
);

  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMG_H - 2);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] TWO      = ADDR_W'(2);

  logic [ADDR_W-1:0] centre_base;
  logic [ADDR_W-1:0] rd_row_base;
  logic [ADDR_W-1:0] rd_col;
  logic [3:0]        slot;
  logic [1:0]        sub;
  rd_mode_t          mode;
  logic              moving_right;
  logic              row_end;

  assign rd_addr = rd_row_base + rd_col;
  assign buf_idx = slot;

  // Serpentine decision: odd centre rows run right, even rows run left,
  // and the row end turns the scan downward.
  always_comb begin
    moving_right = centre_row[0];
    row_end      = moving_right ? (centre_col == LAST_COL) : (centre_col == ONE);
    if (row_end) begin
      next_dir = DIR_DOWN;
    end else if (moving_right) begin
      next_dir = DIR_RIGHT;
    end else begin
      next_dir = DIR_LEFT;
    end
    last_window = row_end && (centre_row == LAST_ROW);
    last_read   = (mode == RD_FILL) ? (slot == SLOT_BR) : (sub == 2'd2);
  end

  // Centre position and read cursor; a move updates the centre and loads
  // the cursor for the pixels that just entered the window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      centre_row  <= ONE;
      centre_col  <= ONE;
      centre_base <= ROW_STEP;
      rd_row_base <= '0;
      rd_col      <= '0;
      slot        <= SLOT_TL;
      sub         <= 2'd0;
      mode        <= RD_FILL;
    end else if (init) begin
      centre_row  <= ONE;
      centre_col  <= ONE;
      centre_base <= ROW_STEP;
      rd_row_base <= '0;
      rd_col      <= '0;
      slot        <= SLOT_TL;
      sub         <= 2'd0;
      mode        <= RD_FILL;
    end else if (move) begin
      sub <= 2'd0;
      case (next_dir)
        DIR_RIGHT: begin
          centre_col  <= centre_col + ONE;
          rd_row_base <= centre_base - ROW_STEP;
          rd_col      <= centre_col + TWO;
          slot        <= SLOT_TR;
          mode        <= RD_COL;
        end
        DIR_LEFT: begin
          centre_col  <= centre_col - ONE;
          rd_row_base <= centre_base - ROW_STEP;
          rd_col      <= centre_col - TWO;
          slot        <= SLOT_TL;
          mode        <= RD_COL;
        end
        DIR_DOWN: begin
          centre_row  <= centre_row + ONE;
          centre_base <= centre_base + ROW_STEP;
          rd_row_base <= centre_base + ROW_STEP + ROW_STEP;
          rd_col      <= centre_col - ONE;
          slot        <= SLOT_BL;
          mode        <= RD_ROW;
        end
        default: begin
          mode <= mode;
        end
      endcase
    end else if (advance) begin
      case (mode)
        RD_FILL: begin
          slot <= slot + 4'd1;
          if (sub == 2'd2) begin
            sub         <= 2'd0;
            rd_col      <= rd_col - TWO;
            rd_row_base <= rd_row_base + ROW_STEP;
          end else begin
            sub    <= sub + 2'd1;
            rd_col <= rd_col + ONE;
          end
        end
        RD_COL: begin
          sub         <= sub + 2'd1;
          slot        <= slot + 4'd3;
          rd_row_base <= rd_row_base + ROW_STEP;
        end
        default: begin
          sub    <= sub + 2'd1;
          slot   <= slot + 4'd1;
          rd_col <= rd_col + ONE;
        end
      endcase
    end
  end

endmodule

// File: rtl/window_scan_ctrl.sv
// Sequencer for the 3x3 windowBuffer: fills the window, presents it to the
// Sobel stage, then shifts and refreshes the entering edge in serpentine
// order until the last window of the frame has been consumed.
module window_scan_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W  = 16,
  parameter int IMG_H  = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              read_done,
  input  logic              shift_done,
  output logic              start_read,
  output logic              start_shift,
  output logic [1:0]        shift_direc,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [3:0]        buf_idx,
  output logic              win_valid,
  input  logic              win_ack,
  output logic [ADDR_W-1:0] win_row,
  output logic [ADDR_W-1:0] win_col,
  output logic              busy,
  output logic              done
);

  scan_state_t       state;
  scan_state_t       next_state;
  logic              pending;
  logic              pend_clr;
  logic              reading;
  shift_dir_t        dir_sel;
  logic              gen_init;
  logic              gen_advance;
  logic              gen_move;
  logic [ADDR_W-1:0] gen_addr;
  logic [3:0]        gen_slot;
  logic [ADDR_W-1:0] gen_row;
  logic [ADDR_W-1:0] gen_col;
  logic              gen_last_read;
  logic              gen_last_window;
  shift_dir_t        gen_next_dir;

  window_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst         (rst),
    .init        (gen_init),
    .advance     (gen_advance),
    .move        (gen_move),
    .rd_addr     (gen_addr),
    .buf_idx     (gen_slot),
    .centre_row  (gen_row),
    .centre_col  (gen_col),
    .last_read   (gen_last_read),
    .last_window (gen_last_window),
    .next_dir    (gen_next_dir)
  );

  // Address, slot, direction and centre are only driven while they mean
  // something, so idle and reset present all-zero outputs.
  assign rd_addr     = reading   ? gen_addr : '0;
  assign buf_idx     = reading   ? gen_slot : 4'd0;
  assign win_row     = win_valid ? gen_row  : '0;
  assign win_col     = win_valid ? gen_col  : '0;
  assign shift_direc = dir_sel;
  assign busy        = (state != ST_IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // One outstanding windowBuffer request at a time; set by the request
  // pulse, cleared by the matching completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= 1'b0;
    end else if (pend_clr) begin
      pending <= 1'b0;
    end else if (start_read || start_shift) begin
      pending <= 1'b1;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    next_state  = state;
    start_read  = 1'b0;
    start_shift = 1'b0;
    dir_sel     = DIR_NONE;
    win_valid   = 1'b0;
    done        = 1'b0;
    gen_init    = 1'b0;
    gen_advance = 1'b0;
    gen_move    = 1'b0;
    pend_clr    = 1'b0;
    reading     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          gen_init   = 1'b1;
          next_state = ST_FILL;
        end
      end
      ST_FILL, ST_EDGE: begin
        reading    = 1'b1;
        start_read = !pending;
        if (pending && read_done) begin
          pend_clr    = 1'b1;
          gen_advance = 1'b1;
          if (gen_last_read) begin
            next_state = ST_PRESENT;
          end
        end
      end
      ST_PRESENT: begin
        win_valid = 1'b1;
        if (win_ack) begin
          next_state = gen_last_window ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        dir_sel     = gen_next_dir;
        start_shift = !pending;
        if (pending && shift_done) begin
          pend_clr   = 1'b1;
          gen_move   = 1'b1;
          next_state = ST_EDGE;
        end
      end
      ST_DONE: begin
        done       = 1'b1;
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Scoreboard bench for window_scan_ctrl on a 4x4 image. The stimulus side
// pushes hand-computed events; a monitor pops one per observed request,
// window presentation or done pulse.
module tb_window_scan_ctrl;

  localparam int IMG_W  = 4;
  localparam int IMG_H  = 4;
  localparam int ADDR_W = 16;

  logic              tb_clk = 1'b0;
  logic              rst;
  logic              start;
  logic              read_done;
  logic              shift_done;
  logic              start_read;
  logic              start_shift;
  logic [1:0]        shift_direc;
  logic [ADDR_W-1:0] rd_addr;
  logic [3:0]        buf_idx;
  logic              win_valid;
  logic              win_ack;
  logic [ADDR_W-1:0] win_row;
  logic [ADDR_W-1:0] win_col;
  logic              busy;
  logic              done;

  logic resp_rd   = 1'b0;
  logic resp_sh   = 1'b0;
  logic spur_rd   = 1'b0;

  assign read_done  = resp_rd | spur_rd;
  assign shift_done = resp_sh;

  typedef enum int {EV_READ, EV_SHIFT, EV_WIN, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       a;
    int       b;
  } ev_t;

  ev_t sb_q[$];
  int  checks    = 0;
  int  failures  = 0;
  int  win_count = 0;

  window_scan_ctrl #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk         (tb_clk),
    .rst         (rst),
    .start       (start),
    .read_done   (read_done),
    .shift_done  (shift_done),
    .start_read  (start_read),
    .start_shift (start_shift),
    .shift_direc (shift_direc),
    .rd_addr     (rd_addr),
    .buf_idx     (buf_idx),
    .win_valid   (win_valid),
    .win_ack     (win_ack),
    .win_row     (win_row),
    .win_col     (win_col),
    .busy        (busy),
    .done        (done)
  );

  always #5 tb_clk = ~tb_clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic pushEv(input ev_kind_t kind, input int a, input int b);
    ev_t e;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    sb_q.push_back(e);
  endtask

  // Pops the next expected event and compares it with what the DUT showed.
  task automatic expectEvent(input ev_kind_t kind, input logic [31:0] a,
                             input logic [31:0] b, input string name);
    ev_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL unexpected_%s actual=%0d,%0d required=no_event", name, a, b);
    end else begin
      e = sb_q.pop_front();
      checkOutput({name, "_kind"}, 32'(kind), 32'(e.kind));
      checkOutput({name, "_a"}, a, 32'(e.a));
      if (kind == EV_READ || kind == EV_WIN) begin
        checkOutput({name, "_b"}, b, 32'(e.b));
      end
    end
  endtask

  // Every output must read zero while idle or in reset.
  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_start_read"},  32'(start_read),  0);
    checkOutput({tag, "_start_shift"}, 32'(start_shift), 0);
    checkOutput({tag, "_shift_direc"}, 32'(shift_direc), 0);
    checkOutput({tag, "_rd_addr"},     32'(rd_addr),     0);
    checkOutput({tag, "_buf_idx"},     32'(buf_idx),     0);
    checkOutput({tag, "_win_valid"},   32'(win_valid),   0);
    checkOutput({tag, "_win_row"},     32'(win_row),     0);
    checkOutput({tag, "_win_col"},     32'(win_col),     0);
    checkOutput({tag, "_busy"},        32'(busy),        0);
    checkOutput({tag, "_done"},        32'(done),        0);
  endtask

  // windowBuffer model: answers each request two cycles after it appears.
  initial begin
    int rc = 0;
    int sc = 0;
    forever begin
      @(posedge tb_clk);
      #1;
      resp_rd = 1'b0;
      resp_sh = 1'b0;
      if (rst) begin
        rc = 0;
        sc = 0;
      end else begin
        if (rc > 0) begin
          rc--;
          if (rc == 0) resp_rd = 1'b1;
        end
        if (sc > 0) begin
          sc--;
          if (sc == 0) resp_sh = 1'b1;
        end
        if (start_read)  rc = 2;
        if (start_shift) sc = 2;
      end
    end
  end

  // Monitor: pops the scoreboard on each observable event and checks that
  // the read address and slot stay put while a read is outstanding.
  initial begin
    logic              prev_valid = 1'b0;
    logic              rd_out     = 1'b0;
    logic              sh_out     = 1'b0;
    logic [ADDR_W-1:0] hold_addr  = '0;
    logic [3:0]        hold_slot  = 4'd0;
    logic [1:0]        hold_dir   = 2'd0;
    forever begin
      @(negedge tb_clk);
      if (rst) begin
        prev_valid = 1'b0;
        rd_out     = 1'b0;
        sh_out     = 1'b0;
      end else begin
        if (rd_out && !start_read) begin
          checkOutput("rd_addr_hold", 32'(rd_addr), 32'(hold_addr));
          checkOutput("buf_idx_hold", 32'(buf_idx), 32'(hold_slot));
          if (read_done) rd_out = 1'b0;
        end
        if (sh_out && !start_shift) begin
          checkOutput("shift_direc_hold", 32'(shift_direc), 32'(hold_dir));
          if (shift_done) sh_out = 1'b0;
        end
        if (start_read) begin
          expectEvent(EV_READ, 32'(rd_addr), 32'(buf_idx), "read");
          rd_out    = 1'b1;
          hold_addr = rd_addr;
          hold_slot = buf_idx;
        end
        if (start_shift) begin
          expectEvent(EV_SHIFT, 32'(shift_direc), 0, "shift");
          sh_out   = 1'b1;
          hold_dir = shift_direc;
        end
        if (win_valid && !prev_valid) begin
          win_count++;
          expectEvent(EV_WIN, 32'(win_row), 32'(win_col), "window");
        end
        if (done) begin
          expectEvent(EV_DONE, 32'(busy), 0, "done");
        end
        prev_valid = win_valid;
      end
    end
  end

  // Bounded wait for the next presented window.
  task automatic waitValid(input int idx, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge tb_clk);
      if (win_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL win_valid_timeout actual=0 required=1 window=%0d", idx);
    end
  endtask

  // Full 4x4 frame with hand-computed reads, shifts and window centres,
  // plus the busy-start, spurious read_done and long-stall cases.
  task automatic applyStimulus();
    bit ok;
    int hold_valid;
    int hold_reqs;
    bit seen_done;
    // FILL around (1,1)
    pushEv(EV_READ, 0, 0);  pushEv(EV_READ, 1, 1);  pushEv(EV_READ, 2, 2);
    pushEv(EV_READ, 4, 3);  pushEv(EV_READ, 5, 4);  pushEv(EV_READ, 6, 5);
    pushEv(EV_READ, 8, 6);  pushEv(EV_READ, 9, 7);  pushEv(EV_READ, 10, 8);
    pushEv(EV_WIN, 1, 1);
    // right to (1,2): new column 3
    pushEv(EV_SHIFT, 1, 0);
    pushEv(EV_READ, 3, 2);  pushEv(EV_READ, 7, 5);  pushEv(EV_READ, 11, 8);
    pushEv(EV_WIN, 1, 2);
    // down to (2,2): new row 3
    pushEv(EV_SHIFT, 2, 0);
    pushEv(EV_READ, 13, 6); pushEv(EV_READ, 14, 7); pushEv(EV_READ, 15, 8);
    pushEv(EV_WIN, 2, 2);
    // left to (2,1): new column 0
    pushEv(EV_SHIFT, 3, 0);
    pushEv(EV_READ, 4, 0);  pushEv(EV_READ, 8, 3);  pushEv(EV_READ, 12, 6);
    pushEv(EV_WIN, 2, 1);
    pushEv(EV_DONE, 1, 0);

    @(negedge tb_clk);
    start = 1'b1;
    @(negedge tb_clk);
    start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 1);
    repeat (3) @(negedge tb_clk);
    start = 1'b1;
    @(negedge tb_clk);
    start = 1'b0;

    for (int w = 0; w < 4; w++) begin
      waitValid(w, ok);
      if (w == 1) begin
        start   = 1'b1;
        spur_rd = 1'b1;
        @(negedge tb_clk);
        start   = 1'b0;
        spur_rd = 1'b0;
        @(negedge tb_clk);
        checkOutput("valid_after_spurious", 32'(win_valid), 1);
        checkOutput("no_read_in_present", 32'(start_read), 0);
      end
      if (w == 3) begin
        hold_valid = 0;
        hold_reqs  = 0;
        for (int c = 0; c < 20; c++) begin
          @(negedge tb_clk);
          if (win_valid) hold_valid++;
          if (start_read || start_shift) hold_reqs++;
        end
        checkOutput("hold_valid_cycles", 32'(hold_valid), 20);
        checkOutput("hold_requests", 32'(hold_reqs), 0);
      end
      win_ack = 1'b1;
      @(negedge tb_clk);
      win_ack = 1'b0;
    end

    seen_done = 1'b0;
    if (done) seen_done = 1'b1;
    for (int i = 0; i < 20 && !seen_done; i++) begin
      @(negedge tb_clk);
      if (done) seen_done = 1'b1;
    end
    checkOutput("done_pulse_seen", 32'(seen_done), 1);
    @(negedge tb_clk);
    checkOutput("done_is_one_cycle", 32'(done), 0);
    checkOutput("busy_after_done", 32'(busy), 0);
    repeat (10) @(negedge tb_clk);
    checkIdleOutputs("post_frame");
    checkOutput("window_count", 32'(win_count), 4);
    checkOutput("scoreboard_left", 32'(sb_q.size()), 0);
  endtask

  // Reset checks, mid-FILL abort, then the full frame.
  initial begin
    bit drained;
    rst     = 1'b1;
    start   = 1'b0;
    win_ack = 1'b0;
    repeat (3) @(posedge tb_clk);
    @(negedge tb_clk);
    checkIdleOutputs("reset");
    rst = 1'b0;

    $display("[TB] reset mid-FILL");
    pushEv(EV_READ, 0, 0);
    pushEv(EV_READ, 1, 1);
    @(negedge tb_clk);
    start = 1'b1;
    @(negedge tb_clk);
    start = 1'b0;
    drained = 1'b0;
    for (int i = 0; i < 50 && !drained; i++) begin
      @(negedge tb_clk);
      if (sb_q.size() == 0) drained = 1'b1;
    end
    checkOutput("abort_reads_seen", 32'(drained), 1);
    checkOutput("busy_mid_fill", 32'(busy), 1);
    #2;
    rst = 1'b1;
    #1;
    checkIdleOutputs("async_reset");
    repeat (2) @(negedge tb_clk);
    sb_q.delete();
    rst = 1'b0;

    $display("[TB] full frame");
    applyStimulus();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
